// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared types and constants for the MEM pipeline stage.
//                Holds the stage FSM state encoding, the data/index widths
//                and the memory-timeout limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_DATA_W    = 16;
    localparam int c_IDX_W     = 4;
    localparam int c_TIMEOUT_W = 8;

    // Number of REQ cycles without an acknowledge before the access is abandoned.
    localparam logic [c_TIMEOUT_W-1:0] c_TIMEOUT_LIMIT = 8'd255;

    // Value written into the read latch when an access times out.
    localparam logic [c_DATA_W-1:0] c_TIMEOUT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_wb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb
//  Description : MEM/WB pipeline register. When load_en_i is high the
//                register either takes the incoming write-back fields or,
//                with bubble_i high, clears only the write enable so that a
//                no-op reaches write-back while index/data hold their values.
//  Ports       : Clk_i, Rst_i (async, active-low)
//                load_en_i, bubble_i          - update control
//                reg_write_i, index_i, data_i - incoming write-back fields
//                reg_write_o, index_o, data_o - registered MEM/WB fields
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb
    import mem_stage_pkg::*;
(
    input  logic                Clk_i,
    input  logic                Rst_i,
    input  logic                load_en_i,
    input  logic                bubble_i,
    input  logic                reg_write_i,
    input  logic [c_IDX_W-1:0]  index_i,
    input  logic [c_DATA_W-1:0] data_i,
    output logic                reg_write_o,
    output logic [c_IDX_W-1:0]  index_o,
    output logic [c_DATA_W-1:0] data_o
);

    logic                reg_write_q, reg_write_d;
    logic [c_IDX_W-1:0]  index_q, index_d;
    logic [c_DATA_W-1:0] data_q, data_d;

    always_comb begin
        reg_write_d = reg_write_q;
        index_d     = index_q;
        data_d      = data_q;
        if (load_en_i) begin
            if (bubble_i) begin
                reg_write_d = 1'b0;
            end else begin
                reg_write_d = reg_write_i;
                index_d     = index_i;
                data_d      = data_i;
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            reg_write_q <= 1'b0;
            index_q     <= '0;
            data_q      <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            index_q     <= index_d;
            data_q      <= data_d;
        end
    end

    assign reg_write_o = reg_write_q;
    assign index_o     = index_q;
    assign data_o      = data_q;

endmodule : mem_wb
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. ALU results pass to MEM/WB with one
//                cycle latency; loads and stores run a request/acknowledge
//                handshake (IDLE -> REQ -> DONE -> IDLE) while holding the
//                upstream pipeline with Stall_o.
//  Config      : MEM_TIMEOUT_EN - when defined, an access that sees no
//                acknowledge for c_TIMEOUT_LIMIT REQ cycles is abandoned,
//                returns 16'hFFFF and sets the sticky MemErr_o flag.
//                When undefined, REQ waits forever and MemErr_o is 0.
//  Ports       : Clk_i, Rst_i (async, active-low)
//                RegWrite2_i, MemotoReg2_i, MemWrite2_i, MemRead2_i,
//                Result2_i, DataIn2_i, RegWriteIndex2_i - EX/MEM inputs
//                MemAddr_o, MemWData_o, MemReq_o, MemWE_o, MemAck_i,
//                MemRData_i                              - memory port
//                Stall_o                                 - pipeline hold
//                RegWrite3_o, RegWriteIndex3_o, WriteData3_o - MEM/WB
//                MemErr_o                                - sticky timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                Clk_i,
    input  logic                Rst_i,
    input  logic                RegWrite2_i,
    input  logic                MemotoReg2_i,
    input  logic                MemWrite2_i,
    input  logic                MemRead2_i,
    input  logic [c_DATA_W-1:0] Result2_i,
    input  logic [c_DATA_W-1:0] DataIn2_i,
    input  logic [c_IDX_W-1:0]  RegWriteIndex2_i,
    output logic [c_DATA_W-1:0] MemAddr_o,
    output logic [c_DATA_W-1:0] MemWData_o,
    output logic                MemReq_o,
    output logic                MemWE_o,
    input  logic                MemAck_i,
    input  logic [c_DATA_W-1:0] MemRData_i,
    output logic                Stall_o,
    output logic                RegWrite3_o,
    output logic [c_IDX_W-1:0]  RegWriteIndex3_o,
    output logic [c_DATA_W-1:0] WriteData3_o,
    output logic                MemErr_o
);

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [c_DATA_W-1:0] addr_q, addr_d;
    logic [c_DATA_W-1:0] wdata_q, wdata_d;
    logic [c_DATA_W-1:0] rlat_q, rlat_d;

    logic                w_mem_op;
    logic                w_stall;
    logic                w_bubble;
    logic                w_timeout;
    logic [c_DATA_W-1:0] w_wb_data;

    assign w_mem_op = MemRead2_i | MemWrite2_i;

    // ------------------------------------------------------------------
    // FSM next-state and memory-port next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rlat_d   = rlat_q;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_mem_op) begin
                    // The instruction stays in EX/MEM; MEM/WB gets a no-op.
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    req_d    = 1'b1;
                    addr_d   = Result2_i;
                    wdata_d  = DataIn2_i;
                    // A read+write request is treated as a write.
                    we_d     = MemWrite2_i;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                // Acknowledge wins over a coincident timeout.
                if (MemAck_i) begin
                    rlat_d  = MemRData_i;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (w_timeout) begin
                    rlat_d  = c_TIMEOUT_DATA;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Never issue from DONE: a following access goes via IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rlat_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rlat_q  <= rlat_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional access timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    logic [c_TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [c_TIMEOUT_W-1:0] w_cnt_inc;
    logic                   err_q, err_d;

    // The incremented value equals the number of REQ cycles spent so far,
    // including the current one.
    assign w_cnt_inc = cnt_q + 8'd1;
    assign w_timeout = (state_q == ST_REQ) && (w_cnt_inc == c_TIMEOUT_LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == ST_IDLE && state_d == ST_REQ) begin
            cnt_d = '0;
        end else if (state_q == ST_REQ) begin
            cnt_d = w_cnt_inc;
        end
        if (w_timeout && !MemAck_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign MemErr_o = err_q;
`else
    assign w_timeout = 1'b0;
    assign MemErr_o  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    assign w_wb_data = (state_q == ST_DONE && MemotoReg2_i) ? rlat_q : Result2_i;

    // MEM is never held by a later stage, so MEM/WB updates every cycle.
    mem_wb u_mem_wb (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .load_en_i   (1'b1),
        .bubble_i    (w_bubble),
        .reg_write_i (RegWrite2_i),
        .index_i     (RegWriteIndex2_i),
        .data_i      (w_wb_data),
        .reg_write_o (RegWrite3_o),
        .index_o     (RegWriteIndex3_o),
        .data_o      (WriteData3_o)
    );

    // Reset gates the hold so upstream stages are free while in reset.
    assign Stall_o    = w_stall & Rst_i;
    assign MemReq_o   = req_q;
    assign MemWE_o    = we_q;
    assign MemAddr_o  = addr_q;
    assign MemWData_o = wdata_q;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Expected write-back
//                values are queued when an instruction is driven and popped
//                when the instruction reaches MEM/WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite2, MemotoReg2, MemWrite2, MemRead2;
    logic [15:0] Result2, DataIn2;
    logic [3:0]  RegWriteIndex2;
    logic [15:0] MemAddr, MemWData;
    logic        MemReq, MemWE;
    logic        MemAck;
    logic [15:0] MemRData;
    logic        Stall;
    logic        RegWrite3;
    logic [3:0]  RegWriteIndex3;
    logic [15:0] WriteData3;
    logic        MemErr;

    typedef struct packed {
        logic        rw;
        logic [3:0]  idx;
        logic [15:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .Clk_i            (clk),
        .Rst_i            (rst_n),
        .RegWrite2_i      (RegWrite2),
        .MemotoReg2_i     (MemotoReg2),
        .MemWrite2_i      (MemWrite2),
        .MemRead2_i       (MemRead2),
        .Result2_i        (Result2),
        .DataIn2_i        (DataIn2),
        .RegWriteIndex2_i (RegWriteIndex2),
        .MemAddr_o        (MemAddr),
        .MemWData_o       (MemWData),
        .MemReq_o         (MemReq),
        .MemWE_o          (MemWE),
        .MemAck_i         (MemAck),
        .MemRData_i       (MemRData),
        .Stall_o          (Stall),
        .RegWrite3_o      (RegWrite3),
        .RegWriteIndex3_o (RegWriteIndex3),
        .WriteData3_o     (WriteData3),
        .MemErr_o         (MemErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        RegWrite2      = 1'b0;
        MemotoReg2     = 1'b0;
        MemWrite2      = 1'b0;
        MemRead2       = 1'b0;
        Result2        = 16'h0000;
        DataIn2        = 16'h0000;
        RegWriteIndex2 = 4'h0;
        MemAck         = 1'b0;
        MemRData       = 16'h0000;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n     = 1'b0;
        MemRead2  = 1'b1;
        MemWrite2 = 1'b1;
        MemAck    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", Stall);
        end
        checks++;
        if ({MemReq, MemWE, MemAddr, MemWData} !== 34'h0) begin
            errors++; $display("FAIL reset_memport: got req=%b we=%b addr=%h wdata=%h want all 0",
                               MemReq, MemWE, MemAddr, MemWData);
        end
        checks++;
        if ({RegWrite3, RegWriteIndex3, WriteData3, MemErr} !== 22'h0) begin
            errors++; $display("FAIL reset_wb: got rw=%b idx=%h data=%h err=%b want all 0",
                               RegWrite3, RegWriteIndex3, WriteData3, MemErr);
        end
        drive_idle();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One ALU op: no stall, result visible after the next edge.
    task automatic test_alu(input logic rw, input logic [3:0] idx, input logic [15:0] res,
                            input logic ack);
        wb_t e, got;
        RegWrite2 = rw; RegWriteIndex2 = idx; Result2 = res; DataIn2 = ~res;
        MemotoReg2 = 1'b1; MemAck = ack; MemRData = 16'h5555;
        e.rw = rw; e.idx = idx; e.data = res;
        exp_q.push_back(e);
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b want 0", Stall);
        end
        tick();
        drive_idle();
        got = {RegWrite3, RegWriteIndex3, WriteData3};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL alu_wb: got rw=%b idx=%h data=%h want rw=%b idx=%h data=%h",
                               got.rw, got.idx, got.data, e.rw, e.idx, e.data);
        end
        checks++;
        if (MemReq !== 1'b0) begin
            errors++; $display("FAIL alu_noreq: got MemReq=%b want 0", MemReq);
        end
    endtask

    // One load/store; the acknowledge arrives after n_wait idle REQ cycles.
    task automatic mem_access(input logic rd, input logic wr, input logic m2r, input logic rw,
                              input logic [15:0] addr, input logic [15:0] din,
                              input logic [15:0] rdata, input logic [3:0] idx,
                              input int n_wait, input logic ack_idle);
        wb_t e, got;
        int  stalls;
        checks++;
        if (MemReq !== 1'b0) begin
            errors++; $display("FAIL mem_pre_idle: got MemReq=%b want 0", MemReq);
        end
        RegWrite2 = rw; MemotoReg2 = m2r; MemWrite2 = wr; MemRead2 = rd;
        Result2 = addr; DataIn2 = din; RegWriteIndex2 = idx;
        MemAck = ack_idle; MemRData = 16'hDEAD;
        e.rw = rw; e.idx = idx; e.data = m2r ? rdata : addr;
        exp_q.push_back(e);
        stalls = 0;
        @(negedge clk);
        if (Stall === 1'b1) stalls++;
        tick();
        MemAck = 1'b0;
        checks++;
        if ({MemReq, MemWE, MemAddr, MemWData} !== {1'b1, wr, addr, din}) begin
            errors++; $display("FAIL mem_issue: got req=%b we=%b addr=%h wdata=%h want req=1 we=%b addr=%h wdata=%h",
                               MemReq, MemWE, MemAddr, MemWData, wr, addr, din);
        end
        for (int k = 0; k <= n_wait; k++) begin
            if (k == n_wait) begin
                MemAck = 1'b1; MemRData = rdata;
            end
            @(negedge clk);
            if (Stall === 1'b1) stalls++;
            checks++;
            if (RegWrite3 !== 1'b0 || MemReq !== 1'b1 || MemWE !== wr || MemAddr !== addr
                || MemWData !== din) begin
                errors++; $display("FAIL mem_req_hold: cycle %0d got rw3=%b req=%b we=%b addr=%h wdata=%h",
                                   k, RegWrite3, MemReq, MemWE, MemAddr, MemWData);
            end
            tick();
            MemAck = 1'b0; MemRData = 16'h0000;
        end
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0 || MemReq !== 1'b0 || MemWE !== 1'b0) begin
            errors++; $display("FAIL mem_done: got stall=%b req=%b we=%b want 0 0 0", Stall, MemReq, MemWE);
        end
        checks++;
        if (stalls != n_wait + 2) begin
            errors++; $display("FAIL mem_stall_len: got %0d want %0d", stalls, n_wait + 2);
        end
        tick();
        got = {RegWrite3, RegWriteIndex3, WriteData3};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL mem_wb: got rw=%b idx=%h data=%h want rw=%b idx=%h data=%h",
                               got.rw, got.idx, got.data, e.rw, e.idx, e.data);
        end
    endtask

    task automatic test_load();
        mem_access(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 4'h3, 3, 1'b0);
        drive_idle();
    endtask

    task automatic test_store();
        // MemAck raised in the IDLE cycle must be ignored.
        mem_access(1'b1, 1'b1, 1'b0, 1'b1, 16'h0022, 16'h00AA, 16'h1111, 4'hC, 1, 1'b1);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        mem_access(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'hCAFE, 4'h1, 0, 1'b0);
        mem_access(1'b1, 1'b0, 1'b1, 1'b1, 16'h0102, 16'h0000, 16'hF00D, 4'h2, 0, 1'b0);
        drive_idle();
    endtask

    task automatic test_reset_mid_req();
        RegWrite2 = 1'b1; MemotoReg2 = 1'b1; MemRead2 = 1'b1;
        Result2 = 16'h0080; RegWriteIndex2 = 4'h6;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemReq !== 1'b0 || Stall !== 1'b0) begin
            errors++; $display("FAIL rst_mid_req: got req=%b stall=%b want 0 0", MemReq, Stall);
        end
        checks++;
        if ({MemWE, MemAddr, MemWData, RegWrite3, RegWriteIndex3, WriteData3, MemErr} !== 55'h0) begin
            errors++; $display("FAIL rst_mid_outs: got we=%b addr=%h wd=%h rw3=%b idx=%h data=%h err=%b want 0",
                               MemWE, MemAddr, MemWData, RegWrite3, RegWriteIndex3, WriteData3, MemErr);
        end
        drive_idle();
        tick();
        rst_n = 1'b1;
        tick();
        // An ALU op right after reset completes in one cycle only from IDLE.
        test_alu(1'b1, 4'h8, 16'h0F0F, 1'b0);
    endtask

    task automatic test_timeout();
        int  n;
        wb_t e, got;
        RegWrite2 = 1'b1; MemotoReg2 = 1'b1; MemRead2 = 1'b1;
        Result2 = 16'h0200; RegWriteIndex2 = 4'h7;
`ifdef MEM_TIMEOUT_EN
        e.rw = 1'b1; e.idx = 4'h7; e.data = 16'hFFFF;
        exp_q.push_back(e);
`endif
        tick();
        n = 0;
        @(negedge clk);
        while (MemReq === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        checks++;
        if (n != 255) begin
            errors++; $display("FAIL timeout_len: got %0d REQ cycles want 255", n);
        end
        checks++;
        if (MemReq !== 1'b0 || MemErr !== 1'b1 || Stall !== 1'b0) begin
            errors++; $display("FAIL timeout_flags: got req=%b err=%b stall=%b want 0 1 0", MemReq, MemErr, Stall);
        end
        tick();
        got = {RegWrite3, RegWriteIndex3, WriteData3};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL timeout_wb: got rw=%b idx=%h data=%h want rw=%b idx=%h data=%h",
                               got.rw, got.idx, got.data, e.rw, e.idx, e.data);
        end
        drive_idle();
        tick();
        checks++;
        if (MemErr !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got MemErr=%b want 1", MemErr);
        end
`else
        checks++;
        if (n != 300 || MemReq !== 1'b1) begin
            errors++; $display("FAIL notimeout_hold: got %0d cycles req=%b want 300 1", n, MemReq);
        end
        checks++;
        if (MemErr !== 1'b0) begin
            errors++; $display("FAIL notimeout_err: got MemErr=%b want 0", MemErr);
        end
        drive_idle();
`endif
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (MemErr !== 1'b0 || MemReq !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: got err=%b req=%b want 0 0", MemErr, MemReq);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_alu(1'b1, 4'h5, 16'h1234, 1'b1);
        test_alu(1'b0, 4'h9, 16'hA5A5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            test_alu(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     16'($urandom_range(0, 65535)), 1'b0);
        end
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid_req();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
